// File: rtl/reg_file_2r1w_pkg.sv
// Address-map helpers shared by the 2-read/1-write register file.
package reg_file_2r1w_pkg;

    typedef enum logic [1:0] {REG_GP, REG_OUT, REG_IN, REG_NONE} region_e;

    function automatic int unsigned n_gp_of(input int unsigned n_reg,
                                            input int unsigned n_in,
                                            input int unsigned n_out);
        return n_reg - n_in - n_out;
    endfunction

    // IN ports sit at the top of the map, OUT registers directly below them.
    function automatic region_e region_of(input int unsigned addr,
                                          input int unsigned n_reg,
                                          input int unsigned n_in,
                                          input int unsigned n_out);
        if (addr >= n_reg)                            return REG_NONE;
        if (addr >= n_reg - n_in)                     return REG_IN;
        if (addr >= n_gp_of(n_reg, n_in, n_out))      return REG_OUT;
        return REG_GP;
    endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Read/write/user-I/O bundle of the register file.
interface reg_file_2r1w_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned N_IN  = 1,
    parameter int unsigned N_OUT = 1
);
    localparam int unsigned IW = ((N_IN  > 0) ? N_IN  : 1) * WIDTH;
    localparam int unsigned OW = ((N_OUT > 0) ? N_OUT : 1) * WIDTH;
    localparam int unsigned SW = (N_OUT > 0) ? N_OUT : 1;

    logic [AW-1:0]    ra_addr;
    logic [WIDTH-1:0] ra_data;
    logic [AW-1:0]    rb_addr;
    logic [WIDTH-1:0] rb_data;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic [IW-1:0]    user_in;
    logic [OW-1:0]    user_out;
    logic [SW-1:0]    out_stb;

    modport master (
        output ra_addr, rb_addr, we, wa, wd, user_in,
        input  ra_data, rb_data, user_out, out_stb
    );

    modport slave (
        input  ra_addr, rb_addr, we, wa, wd, user_in,
        output ra_data, rb_data, user_out, out_stb
    );

endinterface

// File: rtl/reg_file_2r1w_sync_2ff.sv
// Two-stage synchroniser for an asynchronous user input word.
module reg_file_2r1w_sync_2ff #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file: two combinational read ports, one write port, GP / OUT / IN regions.
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned N_REG  = 8,
    parameter int unsigned N_IN   = 1,
    parameter int unsigned N_OUT  = 1,
    parameter int unsigned BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    reg_file_2r1w_if.slave  bus
);

    localparam int unsigned AW   = $clog2(N_REG);
    localparam int unsigned N_GP = n_gp_of(N_REG, N_IN, N_OUT);
    localparam int unsigned N_ST = N_GP + N_OUT;
    localparam int unsigned NI   = (N_IN  > 0) ? N_IN  : 1;
    localparam int unsigned OW   = ((N_OUT > 0) ? N_OUT : 1) * WIDTH;
    localparam int unsigned SW   = (N_OUT > 0) ? N_OUT : 1;

    if (N_REG < 2 || N_IN + N_OUT + 1 > N_REG) begin : g_bad_params
        $error("reg_file_2r1w: N_REG must be >= 2 with at least one GP register");
    end

    logic [WIDTH-1:0] mem   [N_ST];
    logic [WIDTH-1:0] in_q  [NI];
    logic [SW-1:0]    stb_q;
    logic             wr_ok;
    logic [AW-1:0]    rd_addr [2];
    logic [WIDTH-1:0] rd_data [2];
    logic [OW-1:0]    user_out_c;
    region_e          wa_region;

    // Writes land only in GP/OUT storage; IN and unmapped addresses are dropped.
    always_comb begin
        wa_region = region_of(32'(bus.wa), N_REG, N_IN, N_OUT);
        wr_ok     = bus.we && (wa_region == REG_GP || wa_region == REG_OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_ST; i++) mem[i] <= '0;
            stb_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_ST; i++) begin
                if (wr_ok && bus.wa == AW'(i)) mem[i] <= bus.wd;
            end
            for (int unsigned j = 0; j < N_OUT; j++) begin
                stb_q[j] <= wr_ok && (bus.wa == AW'(N_GP + j));
            end
        end
    end

    for (genvar k = 0; k < N_IN; k++) begin : g_sync
        reg_file_2r1w_sync_2ff #(.WIDTH(WIDTH)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (bus.user_in[k*WIDTH +: WIDTH]),
            .q   (in_q[k])
        );
    end
    if (N_IN == 0) begin : g_no_in
        assign in_q[0] = '0;
    end

    assign rd_addr[0] = bus.ra_addr;
    assign rd_addr[1] = bus.rb_addr;

    // Unmapped addresses fall through to zero; forwarding never covers IN ports.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            for (int unsigned i = 0; i < N_ST; i++) begin
                if (rd_addr[p] == AW'(i)) rd_data[p] = mem[i];
            end
            for (int unsigned k = 0; k < N_IN; k++) begin
                if (rd_addr[p] == AW'(N_REG - N_IN + k)) rd_data[p] = in_q[k];
            end
            if (BYPASS != 0 && wr_ok && rd_addr[p] == bus.wa) rd_data[p] = bus.wd;
        end
    end

    always_comb begin
        user_out_c = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            user_out_c[j*WIDTH +: WIDTH] = mem[N_GP + j];
        end
    end

    assign bus.ra_data  = rd_data[0];
    assign bus.rb_data  = rd_data[1];
    assign bus.user_out = user_out_c;
    assign bus.out_stb  = stb_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: default config with forwarding, and a 12-entry config without.
module tb_reg_file_2r1w;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_2r1w_if #(.WIDTH(8), .AW(3), .N_IN(1), .N_OUT(1)) ifa ();
    reg_file_2r1w_if #(.WIDTH(8), .AW(4), .N_IN(2), .N_OUT(2)) ifb ();

    reg_file_2r1w #(.WIDTH(8), .N_REG(8), .N_IN(1), .N_OUT(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    reg_file_2r1w #(.WIDTH(8), .N_REG(12), .N_IN(2), .N_OUT(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus currently driven, per configuration (0 = dut_a, 1 = dut_b).
    logic        s_we  [2];
    int unsigned s_wa  [2];
    int unsigned s_ra  [2];
    int unsigned s_rb  [2];
    logic [7:0]  s_wd  [2];
    logic [15:0] s_uin [2];

    // Reference model: architectural register contents, pending strobes, user_in history.
    logic [7:0]  m_reg [2][16];
    logic [1:0]  m_stb [2];
    logic [15:0] hq0 [$];
    logic [15:0] hq1 [$];

    function automatic int unsigned nreg(input int c); return (c == 0) ? 8 : 12; endfunction
    function automatic int unsigned nin (input int c); return (c == 0) ? 1 : 2;  endfunction
    function automatic int unsigned nout(input int c); return (c == 0) ? 1 : 2;  endfunction
    function automatic int unsigned ngp (input int c); return nreg(c) - nin(c) - nout(c); endfunction
    function automatic bit          byp (input int c); return c == 0; endfunction

    // user_in value sampled two edges ago (zero until two edges have passed since reset)
    function automatic logic [15:0] synced(input int c);
        if (c == 0) return (hq0.size() >= 2) ? hq0[0] : 16'h0;
        return (hq1.size() >= 2) ? hq1[0] : 16'h0;
    endfunction

    function automatic logic [7:0] exp_rd(input int c, input int unsigned a);
        int unsigned nst;
        logic [15:0] h;
        nst = nreg(c) - nin(c);
        if (byp(c) && s_we[c] && s_wa[c] == a && a < nst) return s_wd[c];
        if (a < nst) return m_reg[c][a];
        if (a < nreg(c)) begin
            h = synced(c);
            return h[8*(a - nst) +: 8];
        end
        return 8'h00;
    endfunction

    function automatic logic [15:0] exp_uo(input int c);
        logic [15:0] r;
        r = '0;
        for (int unsigned j = 0; j < nout(c); j++) r[8*j +: 8] = m_reg[c][ngp(c) + j];
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) m_reg[c][a] = 8'h00;
            m_stb[c] = 2'b00;
        end
        hq0.delete();
        hq1.delete();
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            for (int unsigned j = 0; j < 2; j++)
                m_stb[c][j] = (j < nout(c)) && s_we[c] && (s_wa[c] == ngp(c) + j);
            if (s_we[c] && s_wa[c] < nreg(c) - nin(c)) m_reg[c][s_wa[c]] = s_wd[c];
        end
        hq0.push_back(s_uin[0]);
        if (hq0.size() > 2) hq0.delete(0);
        hq1.push_back(s_uin[1]);
        if (hq1.size() > 2) hq1.delete(0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        ifa.we      = s_we[0];
        ifa.wa      = 3'(s_wa[0]);
        ifa.wd      = s_wd[0];
        ifa.ra_addr = 3'(s_ra[0]);
        ifa.rb_addr = 3'(s_rb[0]);
        ifa.user_in = s_uin[0][7:0];
        ifb.we      = s_we[1];
        ifb.wa      = 4'(s_wa[1]);
        ifb.wd      = s_wd[1];
        ifb.ra_addr = 4'(s_ra[1]);
        ifb.rb_addr = 4'(s_rb[1]);
        ifb.user_in = s_uin[1];
    endtask

    task automatic check_all();
        chk("a_ra",  32'(ifa.ra_data),  32'(exp_rd(0, s_ra[0])));
        chk("a_rb",  32'(ifa.rb_data),  32'(exp_rd(0, s_rb[0])));
        chk("a_uo",  32'(ifa.user_out), 32'(exp_uo(0)));
        chk("a_stb", 32'(ifa.out_stb),  32'(m_stb[0][0]));
        chk("b_ra",  32'(ifb.ra_data),  32'(exp_rd(1, s_ra[1])));
        chk("b_rb",  32'(ifb.rb_data),  32'(exp_rd(1, s_rb[1])));
        chk("b_uo",  32'(ifb.user_out), 32'(exp_uo(1)));
        chk("b_stb", 32'(ifb.out_stb),  32'(m_stb[1]));
    endtask

    task automatic settle();
        apply();
        #1;
    endtask

    // One clock: drive, check before the edge, advance the model on the edge.
    task automatic cycle();
        settle();
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wr(input int c, input int unsigned a, input logic [7:0] d);
        s_we[c] = 1'b1;
        s_wa[c] = a;
        s_wd[c] = d;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int c = 0; c < 2; c++) begin
            s_we[c] = 1'b0; s_wa[c] = 0; s_wd[c] = '0;
            s_ra[c] = 0;    s_rb[c] = 0; s_uin[c] = '0;
        end
        rst = 1'b1;
        apply();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_uo",  32'(ifa.user_out), 32'h0);
        chk("rst_a_stb", 32'(ifa.out_stb),  32'h0);
        chk("rst_b_uo",  32'(ifb.user_out), 32'h0);
        chk("rst_b_stb", 32'(ifb.out_stb),  32'h0);
        rst = 1'b0;

        // every address reads zero after reset, on both ports
        for (int unsigned a = 0; a < 16; a++) begin
            s_ra[0] = a & 7; s_rb[0] = 7 - (a & 7);
            s_ra[1] = a;     s_rb[1] = 15 - a;
            cycle();
        end

        // same-cycle forwarding on dut_a only
        for (int c = 0; c < 2; c++) begin
            wr(c, 3, 8'hA5); s_ra[c] = 3; s_rb[c] = 3;
        end
        settle();
        chk("byp_a_ra", 32'(ifa.ra_data), 32'hA5);
        chk("byp_a_rb", 32'(ifa.rb_data), 32'hA5);
        chk("nobyp_b",  32'(ifb.ra_data), 32'h00);
        cycle();
        s_we[0] = 1'b0; s_we[1] = 1'b0;
        settle();
        chk("hold_a", 32'(ifa.ra_data), 32'hA5);
        chk("hold_b", 32'(ifb.rb_data), 32'hA5);
        cycle();

        // OUT registers and strobes; dut_b strobes back-to-back and on unchanged data
        wr(0, 6, 8'h3C); wr(1, 8, 8'h3C);
        cycle();
        s_we[0] = 1'b0; s_ra[0] = 6; wr(1, 9, 8'hC3);
        settle();
        chk("out_a_uo",  32'(ifa.user_out), 32'h3C);
        chk("out_a_stb", 32'(ifa.out_stb),  32'h1);
        chk("out_a_rd",  32'(ifa.ra_data),  32'h3C);
        chk("out_b_stb8", 32'(ifb.out_stb), 32'h1);
        cycle();
        settle();
        chk("out_a_stb_end", 32'(ifa.out_stb), 32'h0);
        chk("out_b_stb9",    32'(ifb.out_stb), 32'h2);
        cycle();
        s_we[1] = 1'b0;
        settle();
        chk("out_b_stb_rewrite", 32'(ifb.out_stb), 32'h2);
        cycle();
        settle();
        chk("out_b_stb_end", 32'(ifb.out_stb),  32'h0);
        chk("out_b_uo",      32'(ifb.user_out), 32'hC33C);
        cycle();

        // IN region: write dropped, read shows user_in two edges later
        wr(0, 7, 8'hFF); s_ra[0] = 7;
        cycle();
        s_we[0] = 1'b0; s_uin[0] = 16'h005A;
        s_ra[1] = 10; s_rb[1] = 11; s_uin[1] = 16'h1234;
        settle();
        chk("in_a_dropped", 32'(ifa.ra_data), 32'h00);
        cycle();
        settle();
        chk("in_a_edge1", 32'(ifa.ra_data), 32'h00);
        cycle();
        settle();
        chk("in_a_edge2",  32'(ifa.ra_data), 32'h5A);
        chk("in_b_slice0", 32'(ifb.ra_data), 32'h34);
        chk("in_b_slice1", 32'(ifb.rb_data), 32'h12);
        cycle();

        // asynchronous reset in the middle of a write
        wr(0, 6, 8'h77);
        cycle();
        wr(0, 2, 8'h11); wr(1, 2, 8'h11);
        settle();
        chk("pre_rst_stb", 32'(ifa.out_stb), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_async_stb", 32'(ifa.out_stb),  32'h0);
        chk("rst_async_uo",  32'(ifa.user_out), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        s_we[0] = 1'b0; s_we[1] = 1'b0; s_ra[0] = 2; s_ra[1] = 2;
        rst = 1'b0;
        settle();
        chk("rst_reg2_a", 32'(ifa.ra_data), 32'h00);
        chk("rst_reg2_b", 32'(ifb.ra_data), 32'h00);
        cycle();

        // unmapped addresses on dut_b
        wr(1, 13, 8'hEE); s_ra[1] = 13; s_rb[1] = 12;
        cycle();
        s_we[1] = 1'b0;
        settle();
        chk("none_b_ra",  32'(ifb.ra_data), 32'h00);
        chk("none_b_rb",  32'(ifb.rb_data), 32'h00);
        chk("none_b_stb", 32'(ifb.out_stb), 32'h0);
        cycle();

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 2; c++) begin
                s_we[c] = 1'($urandom_range(0, 1));
                s_wa[c] = $urandom_range(0, (c == 0) ? 7 : 15);
                s_wd[c] = 8'($urandom);
                s_ra[c] = ($urandom_range(0, 3) == 0) ? s_wa[c] : $urandom_range(0, (c == 0) ? 7 : 15);
                s_rb[c] = $urandom_range(0, (c == 0) ? 7 : 15);
                if ($urandom_range(0, 3) == 0) s_uin[c] = 16'($urandom);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
